// File: rtl/niossoc_debug_pkg.sv
// Shared definitions for the on-chip debug memory controller: jdo field
// positions, controller state encoding and default memory geometry.
package niossoc_debug_pkg;

  localparam int DEFAULT_ADDR_W = 8;
  localparam int JDO_W          = 38;

  localparam int JDO_LOAD       = 17;
  localparam int JDO_READ       = 34;
  localparam int JDO_ADDR_HI    = 26;
  localparam int JDO_ADDR_LO    = 18;
  localparam int JDO_DATA_HI    = 34;
  localparam int JDO_DATA_LO    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_JRD  = 2'd1,
    ST_CRD  = 2'd2
  } ocimem_state_e;

endpackage

// File: rtl/niossoc_debug_ocimem_ram.sv
// Single-port synchronous debug RAM, 1-cycle read latency, byte enables.
// OCIMEM_PARITY_EN adds a 33rd even-parity bit and a read parity-error flag.
module niossoc_debug_ocimem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
`ifdef OCIMEM_PARITY_EN
  output logic              parity_err,
`endif
  output logic [31:0]       q
);

  localparam int DEPTH = 2 ** ADDR_W;

`ifdef OCIMEM_PARITY_EN
  logic [32:0] mem [DEPTH];
  logic [32:0] q_raw;
  logic [31:0] merged;

  // Parity covers the whole word, so partial writes merge with the stored bytes.
  always_comb begin
    merged = mem[addr][31:0];
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= {^merged, merged};
    q_raw <= mem[addr];
  end

  assign q          = q_raw[31:0];
  assign parity_err = ^q_raw;
`else
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    q <= mem[addr];
  end
`endif

endmodule

// File: rtl/niossoc_debug_ocimem_ctrl.sv
// Debug memory controller: executes JTAG load/read/write commands and arbitrates
// CPU Avalon accesses to the debug RAM. Optional parity: define OCIMEM_PARITY_EN.
module niossoc_debug_ocimem_ctrl
  import niossoc_debug_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int ROM_BASE = 192
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic [1:0]        debug_state
);

  ocimem_state_e     state, state_nxt;
  logic [ADDR_W-1:0] jaddr, jaddr_nxt, eff_addr, load_addr;
  logic [31:0]       mon_nxt, rd_hold, rd_hold_nxt;
  logic              ready_nxt, err_nxt, wait_c, take_any;
  logic [8:0]        jdo_addr_field;
  logic              jdo_load, jdo_read;
  logic [31:0]       jdo_data;
  logic              unused_jdo_bits;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we, ram_we_c;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata, ram_q;
`ifdef OCIMEM_PARITY_EN
  logic              ram_parity_err;
`endif

  assign jdo_addr_field  = jdo[JDO_ADDR_HI:JDO_ADDR_LO];
  assign jdo_load        = jdo[JDO_LOAD];
  assign jdo_read        = jdo[JDO_READ];
  assign jdo_data        = jdo[JDO_DATA_HI:JDO_DATA_LO];
  assign unused_jdo_bits = &{jdo[37:35], jdo[2:0]};
  assign load_addr       = jdo_addr_field[ADDR_W-1:0];
  assign take_any        = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

  // Handshakes: take_* are single-cycle pulses, JTAG results are announced by
  // monitor_ready rising; CPU transfers complete on any clk edge where the
  // request is high and avs_waitrequest is low, and JTAG always wins arbitration.
  always_comb begin
    state_nxt   = state;
    jaddr_nxt   = jaddr;
    eff_addr    = jdo_load ? load_addr : jaddr;
    mon_nxt     = MonDReg;
    ready_nxt   = monitor_ready & ~take_any;
    err_nxt     = monitor_error;
    rd_hold_nxt = rd_hold;
    wait_c      = 1'b1;
    ram_addr    = jaddr;
    ram_we_c    = 1'b0;
    ram_be      = 4'hF;
    ram_wdata   = jdo_data;
    case (state)
      ST_IDLE: begin
        if (take_action_ocimem_a) begin
          if (jdo_load) begin
            jaddr_nxt = load_addr;
            err_nxt   = 1'b0;
          end
          if (jdo_read) begin
            ram_addr  = eff_addr;
            jaddr_nxt = eff_addr + ADDR_W'(1);
            state_nxt = ST_JRD;
          end
          if (take_action_ocimem_b) err_nxt = 1'b1;
        end else if (take_action_ocimem_b) begin
          ram_we_c  = 1'b1;
          jaddr_nxt = jaddr + ADDR_W'(1);
        end else if (take_no_action_ocimem_a) begin
          state_nxt = ST_JRD;
        end else if (avs_write) begin
          wait_c    = 1'b0;
          ram_addr  = avs_address;
          ram_be    = avs_byteenable;
          ram_wdata = avs_writedata;
          ram_we_c  = ({1'b0, avs_address} < (ADDR_W+1)'(ROM_BASE));
        end else if (avs_read) begin
          ram_addr  = avs_address;
          state_nxt = ST_CRD;
        end
      end
      ST_JRD: begin
        // The read belongs to an accepted command, so it reports even if a
        // stray pulse lands on the completion cycle.
        mon_nxt   = ram_q;
        ready_nxt = 1'b1;
`ifdef OCIMEM_PARITY_EN
        if (ram_parity_err) err_nxt = 1'b1;
`endif
        if (take_any) err_nxt = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_CRD: begin
        wait_c      = 1'b0;
        rd_hold_nxt = ram_q;
        if (take_any) err_nxt = 1'b1;
        state_nxt   = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      jaddr         <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      rd_hold       <= '0;
    end else begin
      state         <= state_nxt;
      jaddr         <= jaddr_nxt;
      MonDReg       <= mon_nxt;
      monitor_ready <= ready_nxt;
      monitor_error <= err_nxt;
      rd_hold       <= rd_hold_nxt;
    end
  end

  // Reset gates the combinational outputs so a held CPU request cannot
  // complete or write the RAM while the controller is being reset.
  assign ram_we          = ram_we_c & ~reset;
  assign avs_waitrequest = reset | wait_c;
  assign avs_readdata    = reset ? 32'h0 : ((state == ST_CRD) ? ram_q : rd_hold);
  assign debug_state     = state;

  niossoc_debug_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk        (clk),
    .addr       (ram_addr),
    .we         (ram_we),
    .be         (ram_be),
    .wdata      (ram_wdata),
`ifdef OCIMEM_PARITY_EN
    .parity_err (ram_parity_err),
`endif
    .q          (ram_q)
  );

endmodule

// File: tb/tb_niossoc_debug_ocimem_ctrl.sv
// Directed bench for niossoc_debug_ocimem_ctrl: drivers push expected read data
// into queues, a negedge monitor pops and compares on each completed read.
module tb_niossoc_debug_ocimem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [37:0] jdo = '0;
  logic        take_a = 1'b0, take_b = 1'b0, take_na = 1'b0;
  logic [7:0]  avs_address = '0;
  logic        avs_read = 1'b0, avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [3:0]  avs_byteenable = '0;
  logic [31:0] avs_readdata, MonDReg;
  logic        avs_waitrequest, monitor_ready, monitor_error;
  logic [1:0]  debug_state;

  logic [31:0] exp_j_q[$];
  logic [31:0] exp_c_q[$];
  int          checks = 0;
  int          failures = 0;
  time         jtag_done_t = 0, cpu_done_t = 0;
  logic        mr_prev = 1'b0;

  niossoc_debug_ocimem_ctrl dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_a),
    .take_action_ocimem_b    (take_b),
    .take_no_action_ocimem_a (take_na),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .debug_state             (debug_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // scoreboard monitor
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (monitor_ready && !mr_prev) begin
          if (exp_j_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL jtag_unexpected: got %h expected no result", MonDReg);
          end else begin
            e = exp_j_q.pop_front();
            chk("jtag_data", MonDReg, e);
            jtag_done_t = $time;
          end
        end
        if (avs_read && !avs_waitrequest) begin
          if (exp_c_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL cpu_unexpected: got %h expected no result", avs_readdata);
          end else begin
            e = exp_c_q.pop_front();
            chk("cpu_data", avs_readdata, e);
            cpu_done_t = $time;
          end
        end
      end
      mr_prev = monitor_ready;
    end
  end

  // driver tasks
  function automatic logic [37:0] cmd_a(input logic load, input logic [8:0] a, input logic rd);
    logic [37:0] w;
    w = '0;
    w[17] = load;
    w[26:18] = a;
    w[34] = rd;
    return w;
  endfunction

  task automatic wait_ready(input string name);
    int cnt;
    cnt = 1;
    while (!monitor_ready && cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk(name, cnt, 2);
  endtask

  task automatic jtag_a(input logic load, input logic [8:0] a, input logic rd);
    @(posedge clk); #1;
    jdo = cmd_a(load, a, rd);
    take_a = 1'b1;
    @(posedge clk); #1;
    take_a = 1'b0;
    if (rd) wait_ready("jtag_a_latency");
  endtask

  task automatic jtag_b(input logic [31:0] d);
    @(posedge clk); #1;
    jdo = {3'b000, d, 3'b000};
    take_b = 1'b1;
    @(posedge clk); #1;
    take_b = 1'b0;
  endtask

  task automatic jtag_na();
    @(posedge clk); #1;
    take_na = 1'b1;
    @(posedge clk); #1;
    take_na = 1'b0;
    wait_ready("jtag_na_latency");
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    @(posedge clk); #1;
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
    @(negedge clk);
    chk("cpu_wr_wait", {31'b0, avs_waitrequest}, 32'd0);
    @(posedge clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] a, input logic [31:0] e, input int lat);
    int cnt;
    exp_c_q.push_back(e);
    @(posedge clk); #1;
    avs_address = a; avs_read = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (avs_waitrequest && cnt < 10);
    chk("cpu_rd_latency", cnt, lat);
    @(posedge clk); #1;
    avs_read = 1'b0;
  endtask

  task automatic preload(input logic [8:0] a, input logic [31:0] d);
    jtag_a(1'b1, a, 1'b0);
    jtag_b(d);
  endtask

  // stimulus
  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_waitrequest", {31'b0, avs_waitrequest}, 32'd1);
    chk("rst_mondreg", MonDReg, 32'd0);
    chk("rst_ready", {31'b0, monitor_ready}, 32'd0);
    chk("rst_error", {31'b0, monitor_error}, 32'd0);
    chk("rst_readdata", avs_readdata, 32'd0);
    chk("rst_state", {30'b0, debug_state}, 32'd0);

    preload(9'h10, 32'hDEADBEEF);
    jtag_b(32'h11111111);
    preload(9'h30, 32'h11223344);
    preload(9'h40, 32'h40404040);
    jtag_b(32'h41414141);
    preload(9'h50, 32'h50505050);
    preload(9'd200, 32'hCAFE0200);

    // load + read, then jaddr is 0x11 and no_action does not advance it
    exp_j_q.push_back(32'hDEADBEEF);
    jtag_a(1'b1, 9'h10, 1'b1);
    exp_j_q.push_back(32'h11111111);
    jtag_na();
    exp_j_q.push_back(32'h11111111);
    jtag_na();

    // write burst across the top of memory
    preload(9'hFF, 32'hA5A50001);
    jtag_b(32'h5A5A0002);
    exp_j_q.push_back(32'hA5A50001);
    jtag_a(1'b1, 9'hFF, 1'b1);
    exp_j_q.push_back(32'h5A5A0002);
    jtag_a(1'b0, 9'h0, 1'b1);

    // CPU write into the read-only region is acknowledged but has no effect
    cpu_write(8'd200, 32'h12345678, 4'hF);
    exp_j_q.push_back(32'hCAFE0200);
    jtag_a(1'b1, 9'd200, 1'b1);
    cpu_read(8'd200, 32'hCAFE0200, 2);

    // byte-lane write below the ROM region
    cpu_write(8'h30, 32'hAABBCCDD, 4'b0101);
    cpu_read(8'h30, 32'h11BB33DD, 2);

    // contention: JTAG pulse and CPU read start together
    exp_j_q.push_back(32'hDEADBEEF);
    fork
      jtag_a(1'b1, 9'h10, 1'b1);
      cpu_read(8'h30, 32'h11BB33DD, 4);
    join
    chk("contention_order", {31'b0, (jtag_done_t < cpu_done_t)}, 32'd1);

    // write pulse during JRD is dropped and flags an error
    exp_j_q.push_back(32'h40404040);
    @(posedge clk); #1;
    jdo = cmd_a(1'b1, 9'h40, 1'b1);
    take_a = 1'b1;
    @(posedge clk); #1;
    take_a = 1'b0;
    chk("err_state_jrd", {30'b0, debug_state}, 32'd1);
    jdo = {3'b000, 32'hBAD0BAD0, 3'b000};
    take_b = 1'b1;
    @(posedge clk); #1;
    take_b = 1'b0;
    chk("err_set", {31'b0, monitor_error}, 32'd1);
    exp_j_q.push_back(32'h41414141);
    jtag_a(1'b1, 9'h41, 1'b1);
    chk("err_cleared", {31'b0, monitor_error}, 32'd0);

    // simultaneous a and b: load executes, error raised, write dropped
    @(posedge clk); #1;
    jdo = cmd_a(1'b1, 9'h50, 1'b0);
    take_a = 1'b1;
    take_b = 1'b1;
    @(posedge clk); #1;
    take_a = 1'b0;
    take_b = 1'b0;
    chk("dual_err", {31'b0, monitor_error}, 32'd1);
    exp_j_q.push_back(32'h50505050);
    jtag_na();
    chk("dual_err_sticky", {31'b0, monitor_error}, 32'd1);

    // reset while a CPU read sits in CRD
    @(posedge clk); #1;
    avs_address = 8'h30;
    avs_read = 1'b1;
    @(posedge clk); #1;
    chk("crd_state", {30'b0, debug_state}, 32'd2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    avs_read = 1'b0;
    @(negedge clk);
    chk("rst2_waitrequest", {31'b0, avs_waitrequest}, 32'd1);
    chk("rst2_mondreg", MonDReg, 32'd0);
    chk("rst2_state", {30'b0, debug_state}, 32'd0);
    chk("rst2_error", {31'b0, monitor_error}, 32'd0);
    chk("rst2_readdata", avs_readdata, 32'd0);
    exp_j_q.push_back(32'hDEADBEEF);
    jtag_a(1'b1, 9'h10, 1'b1);
    cpu_read(8'h30, 32'h11BB33DD, 2);

    repeat (3) @(posedge clk);
    chk("jtag_queue_empty", exp_j_q.size(), 32'd0);
    chk("cpu_queue_empty", exp_c_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
